// File: rtl/corelet_ctrl_if.sv
// Bundle of the control, corelet strobe and SRAM signals that surround the
// corelet tile controller. The master view belongs to the controller; the
// slave view belongs to whatever hosts it (host logic, memories, array).
interface corelet_ctrl_if #(
  parameter int addr_w = 11,
  parameter int len_w  = 8
);

  // Tile request and configuration
  logic              start;
  logic              abort;
  logic [len_w-1:0]  i_len;
  logic              i_mode;
  logic              i_acc;
  logic [addr_w-1:0] i_w_base;
  logic [addr_w-1:0] i_a_base;
  logic [addr_w-1:0] i_p_base;

  // Corelet status
  logic              ofifo_valid;

  // Corelet instruction and strobes
  logic [1:0]        inst_w;
  logic              l0_wr;
  logic              l0_rd;
  logic              ofifo_rd;
  logic              sfp_acc_en;
  logic              mode;

  // SRAM side
  logic              xmem_cen;
  logic              pmem_cen;
  logic              pmem_wen;
  logic [addr_w-1:0] xmem_addr;
  logic [addr_w-1:0] pmem_addr;

  // Tile status
  logic              busy;
  logic              done;

  modport master (
    input  start, abort, i_len, i_mode, i_acc, i_w_base, i_a_base, i_p_base,
    input  ofifo_valid,
    output inst_w, l0_wr, l0_rd, ofifo_rd, sfp_acc_en, mode,
    output xmem_cen, pmem_cen, pmem_wen, xmem_addr, pmem_addr,
    output busy, done
  );

  modport slave (
    output start, abort, i_len, i_mode, i_acc, i_w_base, i_a_base, i_p_base,
    output ofifo_valid,
    input  inst_w, l0_wr, l0_rd, ofifo_rd, sfp_acc_en, mode,
    input  xmem_cen, pmem_cen, pmem_wen, xmem_addr, pmem_addr,
    input  busy, done
  );

endinterface

// File: rtl/corelet_ctrl.sv
// Corelet tile controller. Sequences one tile: fill L0 with weights from
// XMEM, load them into the PE array, let them settle, stream activations
// through L0 into the array, drain OFIFO rows into PMEM and optionally read
// the partial sums back for an accumulate pass.
//
// Every output is a flop. Strobes for the cycle are computed from the
// current state and land on the pins one cycle later, so l0_wr naturally
// trails the XMEM read that feeds it and sfp_acc_en trails the PMEM read.
// The fill states run one extra cycle after their last read so the final
// delayed l0_wr never coincides with the first l0_rd of the next state.
module corelet_ctrl #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int addr_w = 11,
  parameter int len_w  = 8
) (
  input  logic           clk,
  input  logic           reset,
  corelet_ctrl_if.master bus
);

  // Counter must reach col (fill drain cycle), row+col-1 (settle) and len.
  localparam int cnt_a = len_w + 1;
  localparam int cnt_b = $clog2(row + col + 1);
  localparam int cnt_w = (cnt_a > cnt_b) ? cnt_a : cnt_b;

  localparam logic [cnt_w-1:0] col_end   = cnt_w'(col);
  localparam logic [cnt_w-1:0] col_last  = cnt_w'(col - 1);
  localparam logic [cnt_w-1:0] wait_last = cnt_w'(row + col - 1);

  localparam logic [1:0] inst_idle = 2'b00;
  localparam logic [1:0] inst_load = 2'b01;
  localparam logic [1:0] inst_exec = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_FILL,
    S_W_LOAD,
    S_W_WAIT,
    S_A_FILL,
    S_EXEC,
    S_DRAIN,
    S_ACC,
    S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [cnt_w-1:0]  cnt_q, cnt_d;

  logic [len_w-1:0]  len_q, len_d;
  logic              acc_q, acc_d;
  logic              mode_q, mode_d;
  logic [addr_w-1:0] w_base_q, w_base_d;
  logic [addr_w-1:0] a_base_q, a_base_d;
  logic [addr_w-1:0] p_base_q, p_base_d;

  logic [1:0]        inst_w_q, inst_w_d;
  logic              l0_wr_q, l0_wr_d;
  logic              l0_rd_q, l0_rd_d;
  logic              ofifo_rd_q, ofifo_rd_d;
  logic              sfp_acc_en_q, sfp_acc_en_d;
  logic              xmem_cen_q, xmem_cen_d;
  logic              pmem_cen_q, pmem_cen_d;
  logic              pmem_wen_q, pmem_wen_d;
  logic [addr_w-1:0] xmem_addr_q, xmem_addr_d;
  logic [addr_w-1:0] pmem_addr_q, pmem_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [cnt_w-1:0]  len_end;
  logic [cnt_w-1:0]  len_last;
  logic [addr_w-1:0] cnt_addr;

  assign len_end  = cnt_w'(len_q);
  assign len_last = len_end - cnt_w'(1);
  assign cnt_addr = addr_w'(cnt_q);

  // Next-state, latched configuration and next-cycle strobes.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    acc_d        = acc_q;
    mode_d       = mode_q;
    w_base_d     = w_base_q;
    a_base_d     = a_base_q;
    p_base_d     = p_base_q;
    inst_w_d     = inst_idle;
    l0_wr_d      = xmem_cen_q;
    l0_rd_d      = 1'b0;
    ofifo_rd_d   = 1'b0;
    sfp_acc_en_d = pmem_cen_q & ~pmem_wen_q;
    xmem_cen_d   = 1'b0;
    pmem_cen_d   = 1'b0;
    pmem_wen_d   = 1'b0;
    xmem_addr_d  = '0;
    pmem_addr_d  = '0;
    done_d       = 1'b0;

    if (bus.abort) begin
      state_d      = S_IDLE;
      cnt_d        = '0;
      l0_wr_d      = 1'b0;
      sfp_acc_en_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (bus.start) begin
            if (bus.i_len != '0) begin
              len_d    = bus.i_len;
              acc_d    = bus.i_acc;
              mode_d   = bus.i_mode;
              w_base_d = bus.i_w_base;
              a_base_d = bus.i_a_base;
              p_base_d = bus.i_p_base;
              state_d  = S_W_FILL;
            end else begin
              done_d = 1'b1;
            end
          end
        end

        S_W_FILL: begin
          if (cnt_q == col_end) begin
            state_d = S_W_LOAD;
            cnt_d   = '0;
          end else begin
            xmem_cen_d  = 1'b1;
            xmem_addr_d = w_base_q + cnt_addr;
            cnt_d       = cnt_q + cnt_w'(1);
          end
        end

        S_W_LOAD: begin
          l0_rd_d  = 1'b1;
          inst_w_d = inst_load;
          if (cnt_q == col_last) begin
            state_d = S_W_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + cnt_w'(1);
          end
        end

        S_W_WAIT: begin
          if (cnt_q == wait_last) begin
            state_d = S_A_FILL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + cnt_w'(1);
          end
        end

        S_A_FILL: begin
          if (cnt_q == len_end) begin
            state_d = S_EXEC;
            cnt_d   = '0;
          end else begin
            xmem_cen_d  = 1'b1;
            xmem_addr_d = a_base_q + cnt_addr;
            cnt_d       = cnt_q + cnt_w'(1);
          end
        end

        S_EXEC: begin
          l0_rd_d  = 1'b1;
          inst_w_d = inst_exec;
          if (cnt_q == len_last) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + cnt_w'(1);
          end
        end

        S_DRAIN: begin
          if (bus.ofifo_valid) begin
            ofifo_rd_d  = 1'b1;
            pmem_cen_d  = 1'b1;
            pmem_wen_d  = 1'b1;
            pmem_addr_d = p_base_q + cnt_addr;
            if (cnt_q == len_last) begin
              state_d = acc_q ? S_ACC : S_FIN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + cnt_w'(1);
            end
          end
        end

        S_ACC: begin
          pmem_cen_d  = 1'b1;
          pmem_addr_d = p_base_q + cnt_addr;
          if (cnt_q == len_last) begin
            state_d = S_FIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + cnt_w'(1);
          end
        end

        S_FIN: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase

      if (state_d == S_FIN) begin
        done_d = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // State, configuration and output registers; reset abandons any tile.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      acc_q        <= 1'b0;
      mode_q       <= 1'b0;
      w_base_q     <= '0;
      a_base_q     <= '0;
      p_base_q     <= '0;
      inst_w_q     <= inst_idle;
      l0_wr_q      <= 1'b0;
      l0_rd_q      <= 1'b0;
      ofifo_rd_q   <= 1'b0;
      sfp_acc_en_q <= 1'b0;
      xmem_cen_q   <= 1'b0;
      pmem_cen_q   <= 1'b0;
      pmem_wen_q   <= 1'b0;
      xmem_addr_q  <= '0;
      pmem_addr_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      acc_q        <= acc_d;
      mode_q       <= mode_d;
      w_base_q     <= w_base_d;
      a_base_q     <= a_base_d;
      p_base_q     <= p_base_d;
      inst_w_q     <= inst_w_d;
      l0_wr_q      <= l0_wr_d;
      l0_rd_q      <= l0_rd_d;
      ofifo_rd_q   <= ofifo_rd_d;
      sfp_acc_en_q <= sfp_acc_en_d;
      xmem_cen_q   <= xmem_cen_d;
      pmem_cen_q   <= pmem_cen_d;
      pmem_wen_q   <= pmem_wen_d;
      xmem_addr_q  <= xmem_addr_d;
      pmem_addr_q  <= pmem_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.inst_w     = inst_w_q;
  assign bus.l0_wr      = l0_wr_q;
  assign bus.l0_rd      = l0_rd_q;
  assign bus.ofifo_rd   = ofifo_rd_q;
  assign bus.sfp_acc_en = sfp_acc_en_q;
  assign bus.mode       = mode_q;
  assign bus.xmem_cen   = xmem_cen_q;
  assign bus.pmem_cen   = pmem_cen_q;
  assign bus.pmem_wen   = pmem_wen_q;
  assign bus.xmem_addr  = xmem_addr_q;
  assign bus.pmem_addr  = pmem_addr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed testbench for corelet_ctrl. A negedge recorder collects a trace
// of each tile; each test task drives its scenario and compares the trace
// against hand-computed expectations.
module tb_corelet_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;

  int tests_run = 0;
  int tests_failed = 0;

  corelet_ctrl_if #(.addr_w(11), .len_w(8)) bus ();

  corelet_ctrl #(.row(8), .col(8), .addr_w(11), .len_w(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Trace collected each negedge
  int   xaddr[$];
  int   pw[$];
  int   pr[$];
  int   n_load, n_exec, n_done, n_busy, n_sfp;
  int   overlap, lag_err, sfp_err, wen_err, mode_err;
  int   gap_run, gap;
  bit   seen_load, gap_done;
  bit   prev_xcen, prev_rd, prev_valid;
  logic exp_mode = 1'b0;
  int   valid_mode = 0;
  int   phase = 0;

  task automatic clear_trace();
    xaddr.delete(); pw.delete(); pr.delete();
    n_load = 0; n_exec = 0; n_done = 0; n_busy = 0; n_sfp = 0;
    overlap = 0; lag_err = 0; sfp_err = 0; wen_err = 0; mode_err = 0;
    gap_run = 0; gap = -1; seen_load = 0; gap_done = 0;
    prev_xcen = 0; prev_rd = 0; prev_valid = 0; phase = 0;
  endtask

  function automatic logic [10:0] strobes();
    return {bus.inst_w, bus.l0_wr, bus.l0_rd, bus.ofifo_rd, bus.sfp_acc_en,
            bus.xmem_cen, bus.pmem_cen, bus.pmem_wen, bus.busy, bus.done};
  endfunction

  // Trace recorder
  always @(negedge clk) begin
    if (bus.xmem_cen) xaddr.push_back(int'(bus.xmem_addr));
    if (bus.pmem_cen && bus.pmem_wen) pw.push_back(int'(bus.pmem_addr));
    if (bus.pmem_cen && !bus.pmem_wen) pr.push_back(int'(bus.pmem_addr));
    if (bus.inst_w == 2'b01) n_load++;
    if (bus.inst_w == 2'b10) n_exec++;
    if (bus.done) n_done++;
    if (bus.busy) n_busy++;
    if (bus.sfp_acc_en) n_sfp++;
    if (bus.l0_wr && bus.l0_rd) overlap++;
    if (bus.l0_wr !== prev_xcen) lag_err++;
    if (bus.sfp_acc_en !== prev_rd) sfp_err++;
    if (bus.pmem_wen && !prev_valid) wen_err++;
    if (bus.busy && bus.mode !== exp_mode) mode_err++;
    if (bus.inst_w == 2'b01) begin
      seen_load = 1; gap_run = 0;
    end else if (seen_load && !gap_done) begin
      if (bus.xmem_cen) begin gap = gap_run; gap_done = 1; end
      else gap_run++;
    end
    prev_xcen  = bus.xmem_cen;
    prev_rd    = bus.pmem_cen & ~bus.pmem_wen;
    prev_valid = bus.ofifo_valid;
  end

  // OFIFO valid source: 0 = never, 1 = always, 2 = pattern 1,0,0 repeating
  always @(posedge clk) begin
    #1;
    case (valid_mode)
      1: bus.ofifo_valid = 1'b1;
      2: begin bus.ofifo_valid = (phase == 0); phase = (phase + 1) % 3; end
      default: bus.ofifo_valid = 1'b0;
    endcase
  end

  task automatic start_tile(input int len, input bit m, input bit a,
                            input int wb, input int ab, input int pb);
    @(posedge clk); #1;
    clear_trace();
    exp_mode     = m;
    bus.start    = 1'b1;
    bus.i_len    = len[7:0];
    bus.i_mode   = m;
    bus.i_acc    = a;
    bus.i_w_base = wb[10:0];
    bus.i_a_base = ab[10:0];
    bus.i_p_base = pb[10:0];
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.i_len    = 8'd7;
    bus.i_mode   = ~m;
    bus.i_acc    = ~a;
    bus.i_w_base = 11'd500;
    bus.i_a_base = 11'd600;
    bus.i_p_base = 11'd700;
  endtask

  task automatic wait_idle(input int budget, output bit timed_out);
    timed_out = 1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!bus.busy) begin timed_out = 0; break; end
    end
    repeat (3) @(negedge clk);
    #2;
  endtask

  task automatic test_reset();
    bus.start = 0; bus.abort = 0; bus.i_len = 0; bus.i_mode = 0; bus.i_acc = 0;
    bus.i_w_base = 0; bus.i_a_base = 0; bus.i_p_base = 0;
    #2 reset = 1'b0;
    #20;
    tests_run++;
    if (strobes() !== 11'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_strobes: got %b expected %b", strobes(), 11'b0);
    end
    tests_run++;
    if (bus.mode !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mode: got %b expected 0", bus.mode);
    end
    tests_run++;
    if (bus.xmem_addr !== 11'd0 || bus.pmem_addr !== 11'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_addr: got x=%0d p=%0d expected 0 0", bus.xmem_addr, bus.pmem_addr);
    end
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_basic();
    bit to;
    int exp_x[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 16, 17, 18, 19};
    int exp_p[4]  = '{32, 33, 34, 35};
    valid_mode = 1;
    start_tile(4, 1, 0, 0, 16, 32);
    wait_idle(300, to);
    tests_run++;
    if (to) begin tests_failed++; $display("[TB] FAIL basic_timeout: tile did not finish"); end
    tests_run++;
    if (xaddr.size() != 12) begin tests_failed++; $display("[TB] FAIL basic_xcount: got %0d expected 12", xaddr.size()); end
    for (int i = 0; i < 12; i++) begin
      tests_run++;
      if (((i < xaddr.size()) ? xaddr[i] : -1) != exp_x[i]) begin
        tests_failed++;
        $display("[TB] FAIL basic_xaddr[%0d]: got %0d expected %0d", i, (i < xaddr.size()) ? xaddr[i] : -1, exp_x[i]);
      end
    end
    tests_run++;
    if (n_load != 8) begin tests_failed++; $display("[TB] FAIL basic_load: got %0d expected 8", n_load); end
    tests_run++;
    if (gap != 16) begin tests_failed++; $display("[TB] FAIL basic_wait: got %0d expected 16", gap); end
    tests_run++;
    if (n_exec != 4) begin tests_failed++; $display("[TB] FAIL basic_exec: got %0d expected 4", n_exec); end
    tests_run++;
    if (pw.size() != 4) begin tests_failed++; $display("[TB] FAIL basic_pcount: got %0d expected 4", pw.size()); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (((i < pw.size()) ? pw[i] : -1) != exp_p[i]) begin
        tests_failed++;
        $display("[TB] FAIL basic_paddr[%0d]: got %0d expected %0d", i, (i < pw.size()) ? pw[i] : -1, exp_p[i]);
      end
    end
    tests_run++;
    if (pr.size() != 0) begin tests_failed++; $display("[TB] FAIL basic_no_acc: got %0d reads expected 0", pr.size()); end
    tests_run++;
    if (n_done != 1) begin tests_failed++; $display("[TB] FAIL basic_done: got %0d expected 1", n_done); end
    tests_run++;
    if (overlap != 0) begin tests_failed++; $display("[TB] FAIL basic_l0_overlap: got %0d expected 0", overlap); end
    tests_run++;
    if (lag_err != 0) begin tests_failed++; $display("[TB] FAIL basic_l0wr_lag: got %0d expected 0", lag_err); end
    tests_run++;
    if (mode_err != 0) begin tests_failed++; $display("[TB] FAIL basic_mode: got %0d expected 0", mode_err); end
  endtask

  task automatic test_ofifo_stall();
    bit to;
    int exp_p[4] = '{32, 33, 34, 35};
    valid_mode = 2;
    start_tile(4, 0, 0, 0, 16, 32);
    wait_idle(300, to);
    tests_run++;
    if (to) begin tests_failed++; $display("[TB] FAIL stall_timeout: tile did not finish"); end
    tests_run++;
    if (pw.size() != 4) begin tests_failed++; $display("[TB] FAIL stall_pcount: got %0d expected 4", pw.size()); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (((i < pw.size()) ? pw[i] : -1) != exp_p[i]) begin
        tests_failed++;
        $display("[TB] FAIL stall_paddr[%0d]: got %0d expected %0d", i, (i < pw.size()) ? pw[i] : -1, exp_p[i]);
      end
    end
    tests_run++;
    if (wen_err != 0) begin tests_failed++; $display("[TB] FAIL stall_wen_valid: got %0d expected 0", wen_err); end
    tests_run++;
    if (n_done != 1) begin tests_failed++; $display("[TB] FAIL stall_done: got %0d expected 1", n_done); end
  endtask

  task automatic test_acc_wrap();
    bit to;
    int exp_a[3] = '{2046, 2047, 0};
    valid_mode = 1;
    start_tile(3, 0, 1, 0, 16, 2046);
    wait_idle(300, to);
    tests_run++;
    if (to) begin tests_failed++; $display("[TB] FAIL acc_timeout: tile did not finish"); end
    tests_run++;
    if (pr.size() != 3) begin tests_failed++; $display("[TB] FAIL acc_rcount: got %0d expected 3", pr.size()); end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (((i < pr.size()) ? pr[i] : -1) != exp_a[i]) begin
        tests_failed++;
        $display("[TB] FAIL acc_raddr[%0d]: got %0d expected %0d", i, (i < pr.size()) ? pr[i] : -1, exp_a[i]);
      end
      tests_run++;
      if (((i < pw.size()) ? pw[i] : -1) != exp_a[i]) begin
        tests_failed++;
        $display("[TB] FAIL acc_waddr[%0d]: got %0d expected %0d", i, (i < pw.size()) ? pw[i] : -1, exp_a[i]);
      end
    end
    tests_run++;
    if (n_sfp != 3) begin tests_failed++; $display("[TB] FAIL acc_sfp_count: got %0d expected 3", n_sfp); end
    tests_run++;
    if (sfp_err != 0) begin tests_failed++; $display("[TB] FAIL acc_sfp_lag: got %0d expected 0", sfp_err); end
    tests_run++;
    if (n_done != 1) begin tests_failed++; $display("[TB] FAIL acc_done: got %0d expected 1", n_done); end
  endtask

  task automatic test_zero_len();
    @(posedge clk); #1;
    clear_trace();
    bus.start = 1'b1;
    bus.i_len = 8'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b1) begin tests_failed++; $display("[TB] FAIL zero_done: got %b expected 1", bus.done); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_busy: got %b expected 0", bus.busy); end
    @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_done_pulse: got %b expected 0", bus.done); end
    repeat (3) @(negedge clk);
    #2;
    tests_run++;
    if (n_busy != 0 || n_done != 1) begin
      tests_failed++;
      $display("[TB] FAIL zero_window: got busy=%0d done=%0d expected 0 1", n_busy, n_done);
    end
  endtask

  task automatic test_abort();
    bit to;
    bit found;
    int exp_p[4] = '{32, 33, 34, 35};
    valid_mode = 1;
    start_tile(4, 1, 0, 0, 16, 32);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.inst_w == 2'b10) begin found = 1; break; end
    end
    tests_run++;
    if (!found) begin tests_failed++; $display("[TB] FAIL abort_reach_exec: got no exec expected exec"); end
    @(posedge clk); #1 bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    @(negedge clk);
    tests_run++;
    if (strobes() !== 11'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_strobes: got %b expected %b", strobes(), 11'b0);
    end
    repeat (20) @(negedge clk);
    #2;
    tests_run++;
    if (n_done != 0) begin tests_failed++; $display("[TB] FAIL abort_no_done: got %0d expected 0", n_done); end

    start_tile(4, 1, 0, 0, 16, 32);
    repeat (4) @(posedge clk);
    #1;
    bus.start    = 1'b1;
    bus.i_len    = 8'd2;
    bus.i_p_base = 11'd100;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle(300, to);
    tests_run++;
    if (to) begin tests_failed++; $display("[TB] FAIL abort_second_timeout: tile did not finish"); end
    tests_run++;
    if (n_done != 1) begin tests_failed++; $display("[TB] FAIL abort_second_done: got %0d expected 1", n_done); end
    tests_run++;
    if (xaddr.size() != 12) begin tests_failed++; $display("[TB] FAIL abort_second_xcount: got %0d expected 12", xaddr.size()); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (((i < pw.size()) ? pw[i] : -1) != exp_p[i]) begin
        tests_failed++;
        $display("[TB] FAIL abort_second_paddr[%0d]: got %0d expected %0d", i, (i < pw.size()) ? pw[i] : -1, exp_p[i]);
      end
    end
    tests_run++;
    if (pw.size() != 4) begin tests_failed++; $display("[TB] FAIL abort_second_pcount: got %0d expected 4", pw.size()); end
    tests_run++;
    if (mode_err != 0) begin tests_failed++; $display("[TB] FAIL busy_start_mode: got %0d expected 0", mode_err); end
  endtask

  task automatic test_reset_mid();
    bit found;
    valid_mode = 1;
    start_tile(4, 1, 0, 0, 16, 32);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.pmem_wen) begin found = 1; break; end
    end
    tests_run++;
    if (!found) begin tests_failed++; $display("[TB] FAIL rstmid_reach_drain: got no write expected write"); end
    #1 reset = 1'b0;
    #1;
    tests_run++;
    if (strobes() !== 11'b0) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_strobes: got %b expected %b", strobes(), 11'b0);
    end
    tests_run++;
    if (bus.mode !== 1'b0 || bus.xmem_addr !== 11'd0 || bus.pmem_addr !== 11'd0) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_mode_addr: got m=%b x=%0d p=%0d expected 0 0 0", bus.mode, bus.xmem_addr, bus.pmem_addr);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    tests_run++;
    if (n_done != 0) begin tests_failed++; $display("[TB] FAIL rstmid_no_done: got %0d expected 0", n_done); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_idle: got busy=%b expected 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ofifo_stall();
    test_acc_wrap();
    test_zero_len();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/corelet_ctrl.md
CORELET_CTRL -- requirements
Module: corelet_ctrl

Interface
REQ-001 SHALL have parameter row, default 8, meaning PE rows and L0 lanes.
REQ-002 SHALL have parameter col, default 8, meaning PE columns and weight words per kernel load.
REQ-003 SHALL have parameter addr_w, default 11, meaning XMEM and PMEM address width.
REQ-004 SHALL have parameter len_w, default 8, meaning activation-count width.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 start  input  1  one-cycle request to begin a tile; sampled only in IDLE.
REQ-008 abort  input  1  synchronous abort; returns FSM to IDLE next edge.
REQ-009 i_len  input  len_w  activation vectors per tile, latched at start.
REQ-010 i_mode, i_acc  input  1 each  array mode and accumulate-pass enable, latched at start.
REQ-011 i_w_base, i_a_base, i_p_base  input  addr_w each  weight, activation and psum base addresses, latched at start.
REQ-012 ofifo_valid  input  1  OFIFO holds a complete output row.
REQ-013 inst_w  output  2  array instruction: 01 kernel load, 10 execute, 00 idle.
REQ-014 l0_wr, l0_rd, ofifo_rd, sfp_acc_en  output  1 each  corelet strobes.
REQ-015 mode  output  1  latched i_mode, held stable for the whole tile.
REQ-016 xmem_cen, pmem_cen, pmem_wen  output  1 each  active-high SRAM enable and write strobes.
REQ-017 xmem_addr, pmem_addr  output  addr_w each  SRAM addresses.
REQ-018 busy, done  output  1 each  busy high outside IDLE; done is a one-cycle completion pulse.

Function
REQ-019 SHALL implement states IDLE, W_FILL, W_LOAD, W_WAIT, A_FILL, EXEC, DRAIN, ACC, FIN.
REQ-020 IDLE: start=1 with i_len!=0 -> latch config, go W_FILL; start=1 with i_len=0 -> pulse done next cycle, remain IDLE.
REQ-021 W_FILL: col cycles, xmem_cen=1, xmem_addr=w_base+k (k=0..col-1); l0_wr SHALL follow each read by exactly 1 cycle (SRAM read latency); go W_LOAD after the last l0_wr.
REQ-022 W_LOAD: col cycles, l0_rd=1, inst_w=01; then W_WAIT.
REQ-023 W_WAIT: row+col idle cycles with inst_w=00 for weight propagation; then A_FILL.
REQ-024 A_FILL: len cycles, xmem_addr=a_base+k, l0_wr delayed 1 cycle as in W_FILL; then EXEC.
REQ-025 EXEC: len cycles, l0_rd=1, inst_w=10; then DRAIN.
REQ-026 DRAIN: each cycle ofifo_valid=1 SHALL assert ofifo_rd, pmem_cen=1, pmem_wen=1, pmem_addr=p_base+n, and increment n; ofifo_valid=0 stalls without timeout; after len reads go ACC if acc=1, else FIN.
REQ-027 ACC: len cycles, pmem_cen=1, pmem_wen=0, pmem_addr=p_base+k; sfp_acc_en asserted 1 cycle after each read; then FIN.
REQ-028 FIN: done=1 for one cycle, then IDLE.
REQ-029 Address arithmetic SHALL be modulo 2^addr_w (wrap, no error).
REQ-030 start while busy SHALL be ignored; latched config SHALL NOT change mid-tile.
REQ-031 abort SHALL take priority over all transitions: all strobes 0 next cycle, counters cleared, no done pulse; a pending delayed l0_wr or sfp_acc_en SHALL be cancelled.
REQ-032 All strobes SHALL be registered outputs, never combinational from inputs.
REQ-033 At most one of l0_wr or l0_rd SHALL be high in any cycle.

Reset
REQ-034 While reset=0: state=IDLE; all counters 0; inst_w=00; all strobes, busy, done and mode 0; addresses 0.
REQ-035 Reset asserted mid-tile SHALL abandon the tile immediately (asynchronously), with no done pulse.

Verification
REQ-036 col=8, len=4, acc=0, w_base=0, a_base=16, p_base=32 -> xmem addresses 0..7, then 16..19; 8 inst_w=01 cycles; 16 wait cycles; 4 inst_w=10 cycles; PMEM writes at 32..35; done pulses once.
REQ-037 Same tile, ofifo_valid toggling 1,0,0,1,... -> pmem_wen only on valid cycles; exactly 4 writes, addresses contiguous.
REQ-038 acc=1, len=3, p_base=2046, addr_w=11 -> ACC reads addresses 2046, 2047, 0; sfp_acc_en lags each read by 1 cycle.
REQ-039 start with i_len=0 -> done high the next cycle, busy never high.
REQ-040 abort during EXEC, then start during IDLE -> all strobes low the cycle after abort; second tile completes normally.
REQ-041 reset pulled low during DRAIN -> all outputs 0 immediately; no done; idle after release.
